// File: rtl/cpu_pkg.sv
// Shared arbitration types and port identifiers for the data-cache arbiter.
package cpu_pkg;

    // Arbiter FSM: normal arbitration, or DBG holding the cache across a multi-word access
    typedef enum logic [0:0] {
        ARB_IDLE     = 1'b0,
        ARB_DBG_LOCK = 1'b1
    } arb_state_t;

    // Identifies which port owns a pending load
    localparam logic ARB_PORT_CPU = 1'b0;
    localparam logic ARB_PORT_DBG = 1'b1;

    // 16-bit counter increment that sticks at all-ones
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

endpackage

// File: rtl/dmem_arb_rd_track.sv
// Tracks the single in-flight cache load and returns its data to the port that issued it.
// The cache has a 1-cycle synchronous read, so one register stage of {valid, port} suffices.
module dmem_arb_rd_track
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_accept,
    input  logic              load_port,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata
);

    logic valid_q, valid_d;
    logic port_q, port_d;

    // Next pending-load record: a new load overwrites, otherwise the valid bit drops
    always_comb begin
        valid_d = load_accept;
        port_d  = load_accept ? load_port : port_q;
    end

    // Pending-load register; reset discards any load still in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            port_q  <= ARB_PORT_CPU;
        end else begin
            valid_q <= valid_d;
            port_q  <= port_d;
        end
    end

    // Steer cache read data to the owning port; the other port sees zero
    always_comb begin
        cpu_rvalid = valid_q && (port_q == ARB_PORT_CPU);
        dbg_rvalid = valid_q && (port_q == ARB_PORT_DBG);
        cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
        dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-cache arbiter between the execute stage (CPU) and the debug/loader port (DBG).
// CPU has fixed priority; DBG wins a conflict once it has been denied STARVE_LIMIT
// consecutive cycles, and may lock the cache across several accesses with dbg_lock.
// Optional feature macro: DMEM_ARB_STATS_EN adds cpu_wait_cnt / dbg_grant_cnt outputs.
module dmem_arbiter
    import cpu_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]       cpu_wait_cnt,
    output logic [15:0]       dbg_grant_cnt
`endif
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    arb_state_t state_q, state_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       cpu_accept;
    logic       dbg_accept;
    logic       load_accept;
    logic       load_port;

    // Grant decision: CPU priority in IDLE unless DBG is starved; DBG exclusive while locked
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (cpu_req && dbg_req) begin
                    if (starve_cnt_q == STARVE_MAX) begin
                        dbg_gnt = 1'b1;
                    end else begin
                        cpu_gnt = 1'b1;
                    end
                end else begin
                    cpu_gnt = cpu_req;
                    dbg_gnt = dbg_req;
                end
            end
            ARB_DBG_LOCK: begin
                dbg_gnt = dbg_req;
            end
            default: begin
                cpu_gnt = 1'b0;
                dbg_gnt = 1'b0;
            end
        endcase
    end

    assign cpu_stall  = cpu_req & ~cpu_gnt;
    assign cpu_accept = cpu_req & cpu_gnt;
    assign dbg_accept = dbg_req & dbg_gnt;

    // Next FSM state and starvation count
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (dbg_accept && dbg_lock) begin
                    state_d = ARB_DBG_LOCK;
                end
            end
            ARB_DBG_LOCK: begin
                if (!dbg_lock) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        // A dropped request leaves the count untouched
        if (dbg_accept) begin
            starve_cnt_d = 4'd0;
        end else if (dbg_req && (starve_cnt_q < STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // Arbitration state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            starve_cnt_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Cache port mux: winner's request, or an all-zero idle cycle
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_req & cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
            mem_we    = dbg_req & dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    assign load_accept = (cpu_accept & ~cpu_we) | (dbg_accept & ~dbg_we);
    assign load_port   = dbg_accept ? ARB_PORT_DBG : ARB_PORT_CPU;

    dmem_arb_rd_track #(
        .DATA_W (DATA_W)
    ) u_rd_track (
        .clk         (clk),
        .reset       (reset),
        .load_accept (load_accept),
        .load_port   (load_port),
        .mem_rdata   (mem_rdata),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .dbg_rvalid  (dbg_rvalid),
        .dbg_rdata   (dbg_rdata)
    );

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] cpu_wait_cnt_q, cpu_wait_cnt_d;
    logic [15:0] dbg_grant_cnt_q, dbg_grant_cnt_d;

    // Saturating activity counters: CPU stall cycles and accepted DBG accesses
    always_comb begin
        cpu_wait_cnt_d  = cpu_stall  ? sat_inc16(cpu_wait_cnt_q)  : cpu_wait_cnt_q;
        dbg_grant_cnt_d = dbg_accept ? sat_inc16(dbg_grant_cnt_q) : dbg_grant_cnt_q;
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_wait_cnt_q  <= 16'd0;
            dbg_grant_cnt_q <= 16'd0;
        end else begin
            cpu_wait_cnt_q  <= cpu_wait_cnt_d;
            dbg_grant_cnt_q <= dbg_grant_cnt_d;
        end
    end

    assign cpu_wait_cnt  = cpu_wait_cnt_q;
    assign dbg_grant_cnt = dbg_grant_cnt_q;
`endif

endmodule
